// File: rtl/rotation_cmd_parser.sv
// rtl/rotation_cmd_parser.sv - ASCII rotation command parser ("L"/"R", digits, LF) with command/error counters
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    in_valid/in_ready   byte handshake; in_data is the ASCII byte
//    in_last             last byte of the stream, treated as if an LF followed it
//    valid/ready         parsed-command handshake toward the dial counter
//    direction           1 = 'R', 0 = 'L' (registered, stable while valid)
//    distance            parsed distance, clamped to MAX_DIST (registered)
//    cmd_count           commands transferred downstream, wraps
//    err_count           malformed lines discarded, saturates at 255
module rotation_cmd_parser #(
   parameter logic [15:0] MAX_DIST = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        valid,
   input  logic        ready,
   output logic        direction,
   output logic [15:0] distance,
   output logic [15:0] cmd_count,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      WAIT_DIR = 2'd0,
      DIGITS   = 2'd1,
      SKIP     = 2'd2,
      EMIT     = 2'd3
   } state_t;

   localparam logic [7:0]  CH_LF    = 8'h0A;
   localparam logic [7:0]  CH_CR    = 8'h0D;
   localparam logic [7:0]  CH_SP    = 8'h20;
   localparam logic [7:0]  CH_L     = 8'h4C;
   localparam logic [7:0]  CH_R     = 8'h52;
   localparam logic [7:0]  CH_0     = 8'h30;
   localparam logic [7:0]  CH_9     = 8'h39;
   localparam logic [19:0] MAX_WIDE = {4'd0, MAX_DIST};

   state_t      state_q,     state_d;
   logic [15:0] acc_q,       acc_d;
   logic        digit_q,     digit_d;
   logic        dir_q,       dir_d;
   logic        valid_q,     valid_d;
   logic        direction_q, direction_d;
   logic [15:0] distance_q,  distance_d;
   logic [15:0] cmd_count_q, cmd_count_d;
   logic [7:0]  err_count_q, err_count_d;

   logic        byte_fire;
   logic        is_digit;
   logic        err_inc;
   logic [19:0] acc_sum;
   logic [15:0] acc_clamped;

   // Depends on state only so the upstream never sees a ready that loops back from in_valid.
   assign in_ready  = (state_q != EMIT);
   assign byte_fire = in_valid && in_ready;
   assign is_digit  = (in_data >= CH_0) && (in_data <= CH_9);

   // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
   // acc*10+9 stays below 2^20 for any 16-bit acc, so 20 bits cannot overflow.
   assign acc_sum     = ({4'd0, acc_q} * 20'd10) + {16'd0, in_data[3:0]};
   assign acc_clamped = (acc_sum > MAX_WIDE) ? MAX_DIST : acc_sum[15:0];

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      digit_d     = digit_q;
      dir_d       = dir_q;
      valid_d     = valid_q;
      direction_d = direction_q;
      distance_d  = distance_q;
      cmd_count_d = cmd_count_q;
      err_count_d = err_count_q;
      err_inc     = 1'b0;

      case (state_q)
         WAIT_DIR: begin
            if (byte_fire) begin
               if (in_data == CH_L || in_data == CH_R) begin
                  dir_d   = (in_data == CH_R);
                  acc_d   = 16'd0;
                  digit_d = 1'b0;
                  state_d = DIGITS;
               end else if (in_data == CH_LF || in_data == CH_CR || in_data == CH_SP) begin
                  state_d = WAIT_DIR;
               end else begin
                  err_inc = 1'b1;
                  state_d = SKIP;
               end
            end
         end
         DIGITS: begin
            if (byte_fire) begin
               if (is_digit) begin
                  acc_d   = acc_clamped;
                  digit_d = 1'b1;
               end else if (in_data == CH_CR) begin
                  state_d = DIGITS;
               end else if (in_data == CH_LF) begin
                  if (digit_q) begin
                     state_d = EMIT;
                  end else begin
                     err_inc = 1'b1;
                     state_d = WAIT_DIR;
                  end
               end else begin
                  err_inc = 1'b1;
                  state_d = SKIP;
               end
            end
         end
         SKIP: begin
            if (byte_fire && in_data == CH_LF) begin
               state_d = WAIT_DIR;
            end
         end
         default: begin
            if (ready) begin
               valid_d     = 1'b0;
               cmd_count_d = cmd_count_q + 16'd1;
               state_d     = WAIT_DIR;
            end
         end
      endcase

      // in_last behaves like a trailing LF applied to the post-byte state. A line that
      // already errored on this byte has left DIGITS, so it cannot be counted twice.
      if (byte_fire && in_last) begin
         if (state_d == DIGITS) begin
            if (digit_d) begin
               state_d = EMIT;
            end else begin
               err_inc = 1'b1;
               state_d = WAIT_DIR;
            end
         end else if (state_d != EMIT) begin
            state_d = WAIT_DIR;
         end
      end

      // Output registers load only on entry to EMIT, keeping them stable under backpressure.
      if (state_q != EMIT && state_d == EMIT) begin
         valid_d     = 1'b1;
         direction_d = dir_d;
         distance_d  = acc_d;
      end

      if (err_inc && err_count_q != 8'hFF) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WAIT_DIR;
         acc_q       <= 16'd0;
         digit_q     <= 1'b0;
         dir_q       <= 1'b0;
         valid_q     <= 1'b0;
         direction_q <= 1'b0;
         distance_q  <= 16'd0;
         cmd_count_q <= 16'd0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         digit_q     <= digit_d;
         dir_q       <= dir_d;
         valid_q     <= valid_d;
         direction_q <= direction_d;
         distance_q  <= distance_d;
         cmd_count_q <= cmd_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign valid     = valid_q;
   assign direction = direction_q;
   assign distance  = distance_q;
   assign cmd_count = cmd_count_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_rotation_cmd_parser.sv
// tb/tb_rotation_cmd_parser.sv - directed self-checking bench for rotation_cmd_parser
module tb_rotation_cmd_parser;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic        valid;
   logic        ready;
   logic        direction;
   logic [15:0] distance;
   logic [15:0] cmd_count;
   logic [7:0]  err_count;

   int n_cmp;
   int n_fail;

   rotation_cmd_parser dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .valid     (valid),
      .ready     (ready),
      .direction (direction),
      .distance  (distance),
      .cmd_count (cmd_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one byte for one clock; called only at posedge+1 while the parser is not in EMIT.
   task automatic send(input logic [7:0] b, input logic last);
      check("in_ready_before_byte", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = b;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i], 1'b0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      ready    = 1'b1;
      #12;

      // Reset values
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_valid",     {31'd0, valid},     32'd0);
      check("rst_direction", {31'd0, direction}, 32'd0);
      check("rst_distance",  {16'd0, distance},  32'd0);
      check("rst_cmd_count", {16'd0, cmd_count}, 32'd0);
      check("rst_err_count", {24'd0, err_count}, 32'd0);
      rst_n = 1'b1;
      tick();

      // "L68\nR48\n" with ready held high
      send_str("L68\n");
      check("t1a_valid",     {31'd0, valid},     32'd1);
      check("t1a_in_ready",  {31'd0, in_ready},  32'd0);
      check("t1a_direction", {31'd0, direction}, 32'd0);
      check("t1a_distance",  {16'd0, distance},  32'd68);
      tick();
      check("t1a_valid_drop", {31'd0, valid},     32'd0);
      check("t1a_cmd_count",  {16'd0, cmd_count}, 32'd1);
      send_str("R48\n");
      check("t1b_valid",     {31'd0, valid},     32'd1);
      check("t1b_direction", {31'd0, direction}, 32'd1);
      check("t1b_distance",  {16'd0, distance},  32'd48);
      tick();
      check("t1_cmd_count", {16'd0, cmd_count}, 32'd2);
      check("t1_err_count", {24'd0, err_count}, 32'd0);

      // "R12\n" with ready low for 5 cycles
      do_reset();
      ready = 1'b0;
      send_str("R12\n");
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid",     {31'd0, valid},     32'd1);
         check("t2_hold_in_ready",  {31'd0, in_ready},  32'd0);
         check("t2_hold_direction", {31'd0, direction}, 32'd1);
         check("t2_hold_distance",  {16'd0, distance},  32'd12);
         check("t2_hold_cmd_count", {16'd0, cmd_count}, 32'd0);
         tick();
      end
      ready = 1'b1;
      tick();
      check("t2_valid_drop", {31'd0, valid},     32'd0);
      check("t2_cmd_count",  {16'd0, cmd_count}, 32'd1);
      check("t2_in_ready",   {31'd0, in_ready},  32'd1);
      tick();
      check("t2_cmd_once", {16'd0, cmd_count}, 32'd1);

      // Malformed lines mixed with one good line
      do_reset();
      send_str("X9\nL\nR7a\nL3\n");
      check("t3_valid",     {31'd0, valid},     32'd1);
      check("t3_direction", {31'd0, direction}, 32'd0);
      check("t3_distance",  {16'd0, distance},  32'd3);
      check("t3_err_count", {24'd0, err_count}, 32'd3);
      tick();
      check("t3_cmd_count", {16'd0, cmd_count}, 32'd1);

      // Distance saturation
      do_reset();
      send_str("R99999\n");
      check("t4_valid",     {31'd0, valid},     32'd1);
      check("t4_direction", {31'd0, direction}, 32'd1);
      check("t4_distance",  {16'd0, distance},  32'd65535);
      check("t4_err_count", {24'd0, err_count}, 32'd0);
      tick();
      check("t4_cmd_count", {16'd0, cmd_count}, 32'd1);

      // Leading zero / zero distance
      send_str("R0\n");
      check("t4z_valid",    {31'd0, valid},    32'd1);
      check("t4z_distance", {16'd0, distance}, 32'd0);
      tick();

      // in_last acting as an implicit LF
      do_reset();
      send(8'h4C, 1'b0);
      send(8'h35, 1'b1);
      check("t5_valid",     {31'd0, valid},     32'd1);
      check("t5_direction", {31'd0, direction}, 32'd0);
      check("t5_distance",  {16'd0, distance},  32'd5);
      tick();
      check("t5_cmd_count", {16'd0, cmd_count}, 32'd1);
      send_str("R\r\n");
      send(8'h37, 1'b1);
      check("t5b_err_count", {24'd0, err_count}, 32'd2);
      check("t5b_valid",     {31'd0, valid},     32'd0);
      check("t5b_in_ready",  {31'd0, in_ready},  32'd1);
      tick();
      check("t5b_cmd_count", {16'd0, cmd_count}, 32'd1);

      // Reset during EMIT drops the pending command
      do_reset();
      send_str("Z\nL1\n");
      tick();
      check("t6_pre_cmd", {16'd0, cmd_count}, 32'd1);
      check("t6_pre_err", {24'd0, err_count}, 32'd1);
      ready = 1'b0;
      send_str("L42\n");
      check("t6_emit_valid",    {31'd0, valid},    32'd1);
      check("t6_emit_distance", {16'd0, distance}, 32'd42);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid",    {31'd0, valid},     32'd0);
      check("t6_rst_cmd",      {16'd0, cmd_count}, 32'd0);
      check("t6_rst_err",      {24'd0, err_count}, 32'd0);
      check("t6_rst_in_ready", {31'd0, in_ready},  32'd1);
      #2;
      rst_n = 1'b1;
      ready = 1'b1;
      tick();
      send_str("R1\n");
      check("t6_valid",     {31'd0, valid},     32'd1);
      check("t6_direction", {31'd0, direction}, 32'd1);
      check("t6_distance",  {16'd0, distance},  32'd1);
      tick();
      check("t6_cmd_count", {16'd0, cmd_count}, 32'd1);

      // err_count saturates at 255
      do_reset();
      for (int i = 0; i < 260; i++) begin
         send_str("X\n");
      end
      check("t7_err_sat", {24'd0, err_count}, 32'd255);
      check("t7_cmd",     {16'd0, cmd_count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
